// File: rtl/beat_generator_pkg.sv
// metronome_pkg: shared constants and helpers for the beat generator.
//   BPM_BASE / BPM_STEP : tempo mapping bpm = BPM_BASE + BPM_STEP*sel
//   PERIOD_W            : width of beat period / counters
//   PEND_W              : width of the pendulum position output
//   tempo_period()      : beat period in clocks, evaluated at elaboration only
//   tempo_bpm()         : BPM value for a tempo select code
package metronome_pkg;

    localparam int BPM_BASE  = 40;
    localparam int BPM_STEP  = 10;
    localparam int SEL_W     = 4;
    localparam int NUM_TEMPI = 1 << SEL_W;
    localparam int PERIOD_W  = 28;
    localparam int PEND_W    = 10;
    localparam int PEND_SPAN = 1 << PEND_W;        // acc increment per cycle
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(PEND_SPAN - 1);

    // Only ever called with constant arguments, so the division folds away.
    function automatic logic [PERIOD_W-1:0] tempo_period(input logic [SEL_W-1:0] sel,
                                                         input longint clk_hz);
        longint bpm;
        bpm = longint'(BPM_BASE) + longint'(BPM_STEP) * longint'(sel);
        return PERIOD_W'((clk_hz * 64'sd60) / bpm);
    endfunction

    function automatic logic [7:0] tempo_bpm(input logic [SEL_W-1:0] sel);
        return 8'(BPM_BASE + BPM_STEP * int'(sel));
    endfunction

endpackage

// File: rtl/beat_generator_if.sv
// beat_generator_if: tempo switch input and beat-timing outputs.
//   tempo_switches : raw asynchronous tempo select (driven by board / bench)
//   beat_tick      : one-cycle pulse at the start of each beat
//   beat_idx       : beat position within the bar
//   downbeat       : high while beat_idx == 0
//   bpm            : committed tempo
//   tempo_changed  : one-cycle pulse when a new tempo takes effect
//   pend_pos       : pendulum position 0..1023
// master = beat generator, slave = consumer (renderer) that also owns the switches.
interface beat_generator_if;
    logic [3:0] tempo_switches;
    logic       beat_tick;
    logic [1:0] beat_idx;
    logic       downbeat;
    logic [7:0] bpm;
    logic       tempo_changed;
    logic [9:0] pend_pos;

    modport master (
        input  tempo_switches,
        output beat_tick, beat_idx, downbeat, bpm, tempo_changed, pend_pos
    );

    modport slave (
        output tempo_switches,
        input  beat_tick, beat_idx, downbeat, bpm, tempo_changed, pend_pos
    );
endinterface

// File: rtl/beat_generator_switch_debouncer.sv
// switch_debouncer: 2-flop synchronizer followed by a stability counter.
//   clk, rst  : clock, synchronous active-high reset
//   i_raw     : asynchronous input bus
//   o_value   : committed value (shows the incoming value during the commit cycle)
//   o_commit  : high for the cycle in which a new value is committed
module switch_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_value,
    output logic             o_commit
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1, r_sync2, r_cand, r_committed;
    logic [CNT_W-1:0] r_cnt;

    // Commit is combinational from registers so the top can register its
    // response on the same edge the committed value updates.
    assign o_commit = (r_cnt == CNT_MAX) && (r_cand != r_committed);
    assign o_value  = o_commit ? r_cand : r_committed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_cand      <= '0;
            r_committed <= '0;
            r_cnt       <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;   // saturates; stays armed while stable
            end
            if (o_commit)
                r_committed <= r_cand;
        end
    end
endmodule

// File: rtl/beat_generator.sv
// beat_generator: tempo select -> BPM, beat pulse, bar position, pendulum.
//   clk_100MHz : system clock
//   reset      : synchronous active-high reset
//   bus        : beat_generator_if.master (switch input, all timing outputs)
// Optional feature macro: PENDULUM_EN (pendulum accumulator; otherwise pend_pos = 0).
// A tempo commit restarts the beat: counter to 0, tick, beat_idx 0.
module beat_generator
    import metronome_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int BEATS_PER_BAR   = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    beat_generator_if.master   bus
);
    localparam logic [1:0] LAST_IDX = 2'(BEATS_PER_BAR - 1);

    // Constant period table, one entry per select code.
    logic [PERIOD_W-1:0] w_period_tab [NUM_TEMPI];
    for (genvar g = 0; g < NUM_TEMPI; g++) begin : g_tab
        assign w_period_tab[g] = tempo_period(SEL_W'(g), longint'(CLK_HZ));
    end

    logic [SEL_W-1:0]    w_new_sel;
    logic                w_commit;

    switch_debouncer #(
        .WIDTH           (SEL_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk_100MHz),
        .rst      (reset),
        .i_raw    (bus.tempo_switches),
        .o_value  (w_new_sel),
        .o_commit (w_commit)
    );

    logic [SEL_W-1:0]    r_sel;
    logic [7:0]          r_bpm;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_tick, r_tc, r_down;
    logic [1:0]          r_idx;

    logic [PERIOD_W-1:0] w_period;
    logic                w_wrap, w_beat;
    logic [1:0]          w_idx_nxt;

    assign w_period  = w_period_tab[r_sel];
    assign w_wrap    = (r_cnt == w_period - PERIOD_W'(1));
    assign w_beat    = w_wrap || w_commit;   // commit + wrap together -> one tick
    assign w_idx_nxt = (w_commit || r_idx == LAST_IDX) ? 2'd0 : r_idx + 2'd1;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_sel  <= '0;
            r_bpm  <= tempo_bpm('0);
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
            r_idx  <= LAST_IDX;
            r_down <= 1'b0;
        end else begin
            r_tick <= w_beat;
            r_tc   <= w_commit;
            if (w_commit) begin
                r_sel <= w_new_sel;
                r_bpm <= tempo_bpm(w_new_sel);
            end
            if (w_beat) begin
                r_cnt  <= '0;
                r_idx  <= w_idx_nxt;
                r_down <= (w_idx_nxt == 2'd0);
            end else begin
                r_cnt <= r_cnt + PERIOD_W'(1);
            end
        end
    end

`ifdef PENDULUM_EN
    // Bresenham stepper: PEND_SPAN steps spread evenly over one period,
    // so pos reaches PEND_MAX on the last cycle of the beat.
    logic [PERIOD_W-1:0] r_acc, w_acc_sum, w_acc_nxt;
    logic [PEND_W-1:0]   r_pos, w_pos_nxt, r_pend;
    logic                r_dir, w_dir_nxt;

    assign w_acc_sum = r_acc + PERIOD_W'(PEND_SPAN);

    always_comb begin
        w_acc_nxt = w_acc_sum;
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (w_beat) begin
            w_acc_nxt = '0;
            w_pos_nxt = '0;
            w_dir_nxt = ~r_dir;
        end else if (w_acc_sum >= w_period) begin
            w_acc_nxt = w_acc_sum - w_period;
            if (r_pos != PEND_MAX)
                w_pos_nxt = r_pos + 1'b1;
        end
    end

    // Output is built from next-state so it stays aligned with beat_tick.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_acc  <= '0;
            r_pos  <= '0;
            r_dir  <= 1'b0;
            r_pend <= '0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_pos  <= w_pos_nxt;
            r_dir  <= w_dir_nxt;
            r_pend <= w_dir_nxt ? (PEND_MAX - w_pos_nxt) : w_pos_nxt;
        end
    end

    assign bus.pend_pos = r_pend;
`else
    assign bus.pend_pos = '0;
`endif

    assign bus.beat_tick     = r_tick;
    assign bus.beat_idx      = r_idx;
    assign bus.downbeat      = r_down;
    assign bus.bpm           = r_bpm;
    assign bus.tempo_changed = r_tc;
endmodule
